// File: rtl/user_id_pkg.sv
// Shared types and defaults for the user project ID reader.
package user_id_pkg;

  localparam int ID_WIDTH_DEF = 32;
  localparam int CLK_DIV_DEF  = 4;
  localparam int HALF_DIV     = CLK_DIV_DEF / 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE0 = 3'd1,
    SAMPLE1 = 3'd2,
    SHIFT   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/user_id_sck_gen.sv
// Serial bit-clock divider: sck low for the first half of each bit period,
// high for the second half, with a strobe on the last cycle of each bit.
// Held cleared (counter 0, sck 0) whenever en is low, so every frame starts
// on a clean bit boundary. CLK_DIV is expected to be even and >= 2.
module user_id_sck_gen
  import user_id_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic bit_end
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Divider counter wraps to 0 at the end of every bit.
  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign bit_end = en && (cnt == LAST);

  // sck is registered from the next counter value so it is glitch-free and
  // aligned with the cycle the counter enters the high half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (en) begin
      cnt <= cnt_nxt;
      sck <= (cnt_nxt >= HALF);
    end else begin
      cnt <= '0;
      sck <= 1'b0;
    end
  end

endmodule

// File: rtl/user_id_reader.sv
// Reads the tie-cell project ID twice, latches it when both samples agree,
// and optionally shifts it out MSB-first on csb/sck/sdo.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// SAMPLE0 | first sample of mask_rev into s0
// SAMPLE1 | second sample compared against s0
// SHIFT   | serial frame in progress, csb low
// DONE    | one-cycle completion pulse
module user_id_reader
  import user_id_pkg::*;
#(
  parameter int ID_WIDTH = ID_WIDTH_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic [ID_WIDTH-1:0] mask_rev,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                serial_en,
  input  logic                abort,
  output logic [ID_WIDTH-1:0] id_value,
  output logic                id_valid,
  output logic                id_err,
  output logic                done,
  output logic                csb,
  output logic                sck,
  output logic                sdo
);

  localparam int BW = $clog2(ID_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(ID_WIDTH - 1);

  state_t              state;
  logic [ID_WIDTH-1:0] s0;
  logic [ID_WIDTH-1:0] shreg;
  logic [BW-1:0]       bit_cnt;
  logic                ser_req;
  logic                accept;
  logic                sck_en;
  logic                bit_end;
  logic                frame_end;

  assign accept    = req_valid && req_ready;
  // Stopping the divider in the abort cycle forces sck low on the same edge
  // that raises csb.
  assign sck_en    = (state == SHIFT) && !abort;
  assign frame_end = abort || (bit_end && (bit_cnt == LAST_BIT));

  user_id_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk     (wb_clk_i),
    .rst_n   (wb_rstn_i),
    .en      (sck_en),
    .sck     (sck),
    .bit_end (bit_end)
  );

  // Request FSM with registered handshake, status and serial outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      id_value  <= '0;
      id_valid  <= 1'b0;
      id_err    <= 1'b0;
      done      <= 1'b0;
      csb       <= 1'b1;
      sdo       <= 1'b0;
      s0        <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      ser_req   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            id_valid  <= 1'b0;
            id_err    <= 1'b0;
            ser_req   <= serial_en;
            req_ready <= 1'b0;
            state     <= SAMPLE0;
          end
        end
        SAMPLE0: begin
          s0    <= mask_rev;
          state <= SAMPLE1;
        end
        SAMPLE1: begin
          if (mask_rev == s0) begin
            id_value <= mask_rev;
            if (ser_req) begin
              shreg   <= mask_rev;
              sdo     <= mask_rev[ID_WIDTH-1];
              csb     <= 1'b0;
              bit_cnt <= '0;
              state   <= SHIFT;
            end else begin
              id_valid <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end
          end else begin
            id_err <= 1'b1;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        SHIFT: begin
          if (frame_end) begin
            csb      <= 1'b1;
            sdo      <= 1'b0;
            id_valid <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + BW'(1);
            shreg   <= {shreg[ID_WIDTH-2:0], 1'b0};
            sdo     <= shreg[ID_WIDTH-2];
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          csb       <= 1'b1;
          sdo       <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_id_reader.sv
// Scoreboard bench for user_id_reader: each accepted request pushes its
// expected completion; a negedge monitor pops and compares on every done.
module tb_user_id_reader;

  logic        wb_clk_i;
  logic        wb_rstn_i;
  logic [31:0] mask_rev;
  logic        req_valid;
  logic        req_ready;
  logic        serial_en;
  logic        abort;
  logic [31:0] id_value;
  logic        id_valid;
  logic        id_err;
  logic        done;
  logic        csb;
  logic        sck;
  logic        sdo;

  typedef struct {
    logic [31:0] value;
    logic        valid;
    logic        err;
    int          acc;
    int          lat;
    int          nbits;
    logic [31:0] cap;
    int          csb_low;
  } sb_t;

  sb_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] cap = 0;
  int          nbits = 0;
  int          csb_low = 0;
  int          line_viol = 0;
  logic        prev_sck = 0;
  logic [31:0] model_id = 0;

  user_id_reader dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rstn_i (wb_rstn_i),
    .mask_rev  (mask_rev),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .serial_en (serial_en),
    .abort     (abort),
    .id_value  (id_value),
    .id_valid  (id_valid),
    .id_err    (id_err),
    .done      (done),
    .csb       (csb),
    .sck       (sck),
    .sdo       (sdo)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 10000", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic sb_t mk(logic [31:0] value, logic valid, logic err, int lat,
                             int nb, logic [31:0] c, int cl);
    sb_t e;
    e.value   = value;
    e.valid   = valid;
    e.err     = err;
    e.acc     = 0;
    e.lat     = lat;
    e.nbits   = nb;
    e.cap     = c;
    e.csb_low = cl;
    return e;
  endfunction

  // Monitor: serial capture on sck rising, idle-line rule, scoreboard pop.
  always @(negedge wb_clk_i) begin
    sb_t e;
    if (!wb_rstn_i) begin
      cap      = 0;
      nbits    = 0;
      csb_low  = 0;
      prev_sck = 0;
    end else begin
      if (csb === 1'b1 && (sck !== 1'b0 || sdo !== 1'b0)) line_viol++;
      if (csb === 1'b0) csb_low++;
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        cap = {cap[30:0], sdo};
        nbits++;
      end
      prev_sck = sck;
      if (done === 1'b1) begin
        check("done_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("done_latency", 32'(cyc - e.acc), 32'(e.lat));
          check("id_value",     id_value,         e.value);
          check("id_valid",     32'(id_valid),    32'(e.valid));
          check("id_err",       32'(id_err),      32'(e.err));
          check("serial_bits",  32'(nbits),       32'(e.nbits));
          check("serial_data",  cap,              e.cap);
          check("csb_low_cyc",  32'(csb_low),     32'(e.csb_low));
        end
        cap     = 0;
        nbits   = 0;
        csb_low = 0;
      end
    end
  end

  // Drive one request from a negedge; records the accept cycle and pushes.
  task automatic send(input logic [31:0] val, input logic ser, input sb_t e_in,
                      output int acc);
    sb_t e;
    int  n;
    e         = e_in;
    mask_rev  = val;
    serial_en = ser;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    acc   = cyc + 1;
    e.acc = acc;
    sb.push_back(e);
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    serial_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge wb_clk_i);
  endtask

  initial begin
    int acc;
    int prev_acc;
    int n_acc;

    wb_rstn_i = 1'b0;
    mask_rev  = 32'h0;
    req_valid = 1'b0;
    serial_en = 1'b0;
    abort     = 1'b0;
    repeat (3) @(negedge wb_clk_i);

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_id_value",  id_value,       32'h0);
    check("rst_id_valid",  32'(id_valid),  32'd0);
    check("rst_id_err",    32'(id_err),    32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_csb",       32'(csb),       32'd1);
    check("rst_sck",       32'(sck),       32'd0);
    check("rst_sdo",       32'(sdo),       32'd0);
    wb_rstn_i = 1'b1;
    @(negedge wb_clk_i);

    // Plain parallel read.
    model_id = 32'hDEADBEEF;
    send(32'hDEADBEEF, 1'b0, mk(model_id, 1'b1, 1'b0, 2, 0, 32'h0, 0), acc);
    drain(20);
    check("id_valid_hold", 32'(id_valid), 32'd1);

    // Full serial frame.
    model_id = 32'hA5000001;
    send(32'hA5000001, 1'b1, mk(model_id, 1'b1, 1'b0, 130, 32, 32'hA5000001, 128), acc);
    drain(200);

    // Sample mismatch: value changes between the two samples.
    send(32'h12345678, 1'b1, mk(model_id, 1'b0, 1'b1, 2, 0, 32'h0, 0), acc);
    @(negedge wb_clk_i);
    mask_rev = 32'h12345679;
    drain(20);
    check("err_hold",   32'(id_err),   32'd1);
    check("err_no_val", 32'(id_valid), 32'd0);

    // Abort during bit 5 of an all-ones frame (SHIFT cycle 21, sck low).
    model_id = 32'hFFFFFFFF;
    send(32'hFFFFFFFF, 1'b1, mk(model_id, 1'b1, 1'b0, 24, 5, 32'h1F, 22), acc);
    while (cyc < acc + 2 + 21) @(negedge wb_clk_i);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    check("abort_csb",  32'(csb),  32'd1);
    check("abort_sck",  32'(sck),  32'd0);
    check("abort_sdo",  32'(sdo),  32'd0);
    check("abort_done", 32'(done), 32'd1);
    drain(20);

    // req_valid held high: accepts every 4 cycles.
    model_id  = 32'h00C0FFEE;
    mask_rev  = 32'h00C0FFEE;
    serial_en = 1'b0;
    req_valid = 1'b1;
    prev_acc  = -1;
    n_acc     = 0;
    for (int i = 0; i < 14; i++) begin
      if (req_ready === 1'b1) begin
        sb_t e;
        e     = mk(model_id, 1'b1, 1'b0, 2, 0, 32'h0, 0);
        e.acc = cyc + 1;
        sb.push_back(e);
        if (prev_acc >= 0) check("b2b_spacing", 32'(e.acc - prev_acc), 32'd4);
        prev_acc = e.acc;
        n_acc++;
      end
      @(negedge wb_clk_i);
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    drain(20);

    // Reset pulse in the middle of a serial frame.
    send(32'hA5000001, 1'b1, mk(32'h0, 1'b0, 1'b0, 0, 0, 32'h0, 0), acc);
    while (cyc < acc + 2 + 50) @(negedge wb_clk_i);
    check("pre_rst_csb", 32'(csb), 32'd0);
    wb_rstn_i = 1'b0;
    #1;
    sb.delete();
    model_id = 32'h0;
    check("mid_rst_csb",      32'(csb),      32'd1);
    check("mid_rst_sck",      32'(sck),      32'd0);
    check("mid_rst_sdo",      32'(sdo),      32'd0);
    check("mid_rst_id_value", id_value,      model_id);
    check("mid_rst_id_valid", 32'(id_valid), 32'd0);
    repeat (2) @(negedge wb_clk_i);
    wb_rstn_i = 1'b1;
    @(negedge wb_clk_i);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_csb",   32'(csb),       32'd1);

    // Fresh request after reset.
    model_id = 32'h0BADF00D;
    send(32'h0BADF00D, 1'b0, mk(model_id, 1'b1, 1'b0, 2, 0, 32'h0, 0), acc);
    drain(20);

    check("idle_lines_low", 32'(line_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
